// File: rtl/voxel_pkg.sv
// -----------------------------------------------------------------------------
// voxel_pkg
// Shared constants and helpers for the voxel DDA marcher:
//   - result status codes returned on res_status
//   - face axis codes used in res_face[1:0]
//   - bit position of the alpha byte inside a voxel word
//   - marcher FSM state encoding
//   - voxel address packing {x,y,z}
// -----------------------------------------------------------------------------
package voxel_pkg;

    localparam logic [1:0] ST_HIT   = 2'd0;
    localparam logic [1:0] ST_EXIT  = 2'd1;
    localparam logic [1:0] ST_LIMIT = 2'd2;

    localparam logic [1:0] AX_X    = 2'd0;
    localparam logic [1:0] AX_Y    = 2'd1;
    localparam logic [1:0] AX_Z    = 2'd2;
    localparam logic [1:0] AX_NONE = 2'd3;

    localparam int VOX_ALPHA_LSB = 40;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Packs three coordinates of gb bits each as {x,y,z}; the caller narrows
    // the result to 3*gb bits. Coordinates are passed zero-extended to 16 bits.
    function automatic logic [47:0] pack_addr(input int unsigned gb,
                                              input logic [15:0] x,
                                              input logic [15:0] y,
                                              input logic [15:0] z);
        logic [47:0] r;
        r = ({32'd0, x} << (gb + gb)) | ({32'd0, y} << gb) | {32'd0, z};
        return r;
    endfunction

endpackage

// File: rtl/voxel_dda_step.sv
// -----------------------------------------------------------------------------
// voxel_dda_step
// Purely combinational single DDA step. Chooses the axis whose next boundary
// crossing comes first (ties: x, then y, then z), moves that coordinate one
// voxel in the ray's direction and advances its t_max by t_del (saturating).
// Ports:
//   vox_x/y/z        in   current voxel
//   tmax_x/y/z       in   t at the next boundary per axis
//   tdel_x/y/z       in   t increment per voxel per axis
//   neg              in   per-axis step sign {z,y,x}, 1 = decrement
//   axis, sign       out  selected axis code and its step sign
//   new_x/y/z        out  voxel after the step
//   new_tmax_x/y/z   out  t_max after the step
//   t_cur            out  t at entry to the new voxel
//   out_of_grid      out  the step would leave the grid
// -----------------------------------------------------------------------------
module voxel_dda_step
    import voxel_pkg::*;
#(
    parameter int GRID_BITS = 6,
    parameter int T_W       = 24
) (
    input  logic [GRID_BITS-1:0] vox_x,
    input  logic [GRID_BITS-1:0] vox_y,
    input  logic [GRID_BITS-1:0] vox_z,
    input  logic [T_W-1:0]       tmax_x,
    input  logic [T_W-1:0]       tmax_y,
    input  logic [T_W-1:0]       tmax_z,
    input  logic [T_W-1:0]       tdel_x,
    input  logic [T_W-1:0]       tdel_y,
    input  logic [T_W-1:0]       tdel_z,
    input  logic [2:0]           neg,
    output logic [1:0]           axis,
    output logic                 sign,
    output logic [GRID_BITS-1:0] new_x,
    output logic [GRID_BITS-1:0] new_y,
    output logic [GRID_BITS-1:0] new_z,
    output logic [T_W-1:0]       new_tmax_x,
    output logic [T_W-1:0]       new_tmax_y,
    output logic [T_W-1:0]       new_tmax_z,
    output logic [T_W-1:0]       t_cur,
    output logic                 out_of_grid
);

    localparam logic [GRID_BITS-1:0] COORD_ZERO = {GRID_BITS{1'b0}};
    localparam logic [GRID_BITS-1:0] COORD_MAX  = {GRID_BITS{1'b1}};
    localparam logic [GRID_BITS-1:0] COORD_ONE  = {{(GRID_BITS-1){1'b0}}, 1'b1};

    // Unsigned add clamped to all-ones so a far boundary never wraps to near.
    function automatic logic [T_W-1:0] sat_add(input logic [T_W-1:0] a,
                                               input logic [T_W-1:0] b);
        logic [T_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[T_W]) begin
            return {T_W{1'b1}};
        end else begin
            return s[T_W-1:0];
        end
    endfunction

    logic [GRID_BITS-1:0] coord_s;
    logic [GRID_BITS-1:0] stepped_s;
    logic [T_W-1:0]       tsel_s;
    logic [T_W-1:0]       dsel_s;
    logic [T_W-1:0]       tnext_s;

    // Earliest boundary wins; <= comparisons give x priority, then y.
    always_comb begin
        if ((tmax_x <= tmax_y) && (tmax_x <= tmax_z)) begin
            axis = AX_X;
        end else if (tmax_y <= tmax_z) begin
            axis = AX_Y;
        end else begin
            axis = AX_Z;
        end
    end

    // Route the chosen axis' coordinate, t_max, t_del and sign to one stepper.
    always_comb begin
        coord_s = vox_x;
        tsel_s  = tmax_x;
        dsel_s  = tdel_x;
        sign    = neg[0];
        case (axis)
            AX_X: begin
                coord_s = vox_x;
                tsel_s  = tmax_x;
                dsel_s  = tdel_x;
                sign    = neg[0];
            end
            AX_Y: begin
                coord_s = vox_y;
                tsel_s  = tmax_y;
                dsel_s  = tdel_y;
                sign    = neg[1];
            end
            AX_Z: begin
                coord_s = vox_z;
                tsel_s  = tmax_z;
                dsel_s  = tdel_z;
                sign    = neg[2];
            end
            default: begin
                coord_s = vox_x;
                tsel_s  = tmax_x;
                dsel_s  = tdel_x;
                sign    = neg[0];
            end
        endcase
    end

    // Step the selected coordinate and flag a move off either grid edge.
    always_comb begin
        stepped_s   = sign ? (coord_s - COORD_ONE) : (coord_s + COORD_ONE);
        tnext_s     = sat_add(tsel_s, dsel_s);
        out_of_grid = sign ? (coord_s == COORD_ZERO) : (coord_s == COORD_MAX);
        t_cur       = tsel_s;
        new_x       = vox_x;
        new_y       = vox_y;
        new_z       = vox_z;
        new_tmax_x  = tmax_x;
        new_tmax_y  = tmax_y;
        new_tmax_z  = tmax_z;
        case (axis)
            AX_X: begin
                new_x      = stepped_s;
                new_tmax_x = tnext_s;
            end
            AX_Y: begin
                new_y      = stepped_s;
                new_tmax_y = tnext_s;
            end
            AX_Z: begin
                new_z      = stepped_s;
                new_tmax_z = tnext_s;
            end
            default: begin
                new_x = vox_x;
            end
        endcase
    end

endmodule

// File: rtl/voxel_dda_marcher.sv
// -----------------------------------------------------------------------------
// voxel_dda_marcher
// Per-ray 3D DDA voxel marcher. Accepts one ray, fetches voxels one at a time
// from a variable-latency memory, stops on an alpha hit, on leaving the grid or
// on the step limit, and returns a hit record.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ray_valid/ray_ready             ray descriptor handshake
//   ray_id, ray_vox_*, ray_neg,
//   ray_tmax_*, ray_tdel_*          ray descriptor fields
//   alpha_thresh                    hit threshold, sampled at ray accept
//   mem_req_valid/ready, _addr      voxel read request {x,y,z}
//   mem_rsp_valid, mem_rsp_data     read response, one pulse per request
//   res_valid/res_ready             result handshake
//   res_id, res_status, res_vox_*,
//   res_face, res_steps, res_t,
//   res_data                        result record
// -----------------------------------------------------------------------------
module voxel_dda_marcher
    import voxel_pkg::*;
#(
    parameter int GRID_BITS = 6,
    parameter int T_W       = 24,
    parameter int MAX_STEPS = 64,
    parameter int DATA_W    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ray_valid,
    output logic                   ray_ready,
    input  logic [15:0]            ray_id,
    input  logic [GRID_BITS-1:0]   ray_vox_x,
    input  logic [GRID_BITS-1:0]   ray_vox_y,
    input  logic [GRID_BITS-1:0]   ray_vox_z,
    input  logic [2:0]             ray_neg,
    input  logic [T_W-1:0]         ray_tmax_x,
    input  logic [T_W-1:0]         ray_tmax_y,
    input  logic [T_W-1:0]         ray_tmax_z,
    input  logic [T_W-1:0]         ray_tdel_x,
    input  logic [T_W-1:0]         ray_tdel_y,
    input  logic [T_W-1:0]         ray_tdel_z,
    input  logic [7:0]             alpha_thresh,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [3*GRID_BITS-1:0] mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [DATA_W-1:0]      mem_rsp_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [15:0]            res_id,
    output logic [1:0]             res_status,
    output logic [GRID_BITS-1:0]   res_vox_x,
    output logic [GRID_BITS-1:0]   res_vox_y,
    output logic [GRID_BITS-1:0]   res_vox_z,
    output logic [2:0]             res_face,
    output logic [7:0]             res_steps,
    output logic [T_W-1:0]         res_t,
    output logic [DATA_W-1:0]      res_data
);

    localparam int          AW         = 3 * GRID_BITS;
    localparam logic [7:0]  STEP_LIMIT = 8'(MAX_STEPS);
    localparam logic [2:0]  FACE_START = {1'b0, AX_NONE};

    state_t               state_r, state_s;
    logic                 ray_ready_r, ray_ready_s;
    logic                 mem_req_valid_r, mem_req_valid_s;
    logic                 res_valid_r, res_valid_s;

    logic [15:0]          id_r;
    logic [GRID_BITS-1:0] x_r, y_r, z_r;
    logic [2:0]           neg_r;
    logic [T_W-1:0]       tmax_x_r, tmax_y_r, tmax_z_r;
    logic [T_W-1:0]       tdel_x_r, tdel_y_r, tdel_z_r;
    logic [7:0]           thresh_r;
    logic [7:0]           steps_r;
    logic [2:0]           face_r;
    logic [T_W-1:0]       t_cur_r;
    logic [DATA_W-1:0]    data_r;
    logic [1:0]           status_r;

    logic [1:0]           step_axis_s;
    logic                 step_sign_s;
    logic [GRID_BITS-1:0] step_x_s, step_y_s, step_z_s;
    logic [T_W-1:0]       step_tmax_x_s, step_tmax_y_s, step_tmax_z_s;
    logic [T_W-1:0]       step_t_s;
    logic                 step_oog_s;

    logic accept_s, req_fire_s, rsp_fire_s, res_fire_s, hit_s, limit_s;

    voxel_dda_step #(
        .GRID_BITS (GRID_BITS),
        .T_W       (T_W)
    ) u_step (
        .vox_x       (x_r),
        .vox_y       (y_r),
        .vox_z       (z_r),
        .tmax_x      (tmax_x_r),
        .tmax_y      (tmax_y_r),
        .tmax_z      (tmax_z_r),
        .tdel_x      (tdel_x_r),
        .tdel_y      (tdel_y_r),
        .tdel_z      (tdel_z_r),
        .neg         (neg_r),
        .axis        (step_axis_s),
        .sign        (step_sign_s),
        .new_x       (step_x_s),
        .new_y       (step_y_s),
        .new_z       (step_z_s),
        .new_tmax_x  (step_tmax_x_s),
        .new_tmax_y  (step_tmax_y_s),
        .new_tmax_z  (step_tmax_z_s),
        .t_cur       (step_t_s),
        .out_of_grid (step_oog_s)
    );

    // Responses are only meaningful while waiting; anything else is dropped.
    assign accept_s   = ray_valid & ray_ready_r;
    assign req_fire_s = (state_r == S_REQ) & mem_req_valid_r & mem_req_ready;
    assign rsp_fire_s = (state_r == S_WAIT) & mem_rsp_valid;
    assign res_fire_s = (state_r == S_OUT) & res_valid_r & res_ready;
    assign hit_s      = mem_rsp_data[VOX_ALPHA_LSB +: 8] > thresh_r;
    assign limit_s    = (steps_r == STEP_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (req_fire_s) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (!rsp_fire_s) begin
                    state_s = S_WAIT;
                end else if (hit_s || limit_s || step_oog_s) begin
                    state_s = S_OUT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_OUT: begin
                if (res_fire_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they can be
    // registered and still change on the same edge as the state.
    always_comb begin
        ray_ready_s     = (state_s == S_IDLE);
        mem_req_valid_s = (state_s == S_REQ);
        res_valid_s     = (state_s == S_OUT);
    end

    // Handshake output registers; all low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ray_ready_r     <= 1'b0;
            mem_req_valid_r <= 1'b0;
            res_valid_r     <= 1'b0;
        end else begin
            ray_ready_r     <= ray_ready_s;
            mem_req_valid_r <= mem_req_valid_s;
            res_valid_r     <= res_valid_s;
        end
    end

    // Ray state: load on accept, count fetches, then resolve each response.
    // A step that would leave the grid leaves position, t and face untouched
    // so the result describes the last voxel actually fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r     <= 16'd0;
            x_r      <= {GRID_BITS{1'b0}};
            y_r      <= {GRID_BITS{1'b0}};
            z_r      <= {GRID_BITS{1'b0}};
            neg_r    <= 3'd0;
            tmax_x_r <= {T_W{1'b0}};
            tmax_y_r <= {T_W{1'b0}};
            tmax_z_r <= {T_W{1'b0}};
            tdel_x_r <= {T_W{1'b0}};
            tdel_y_r <= {T_W{1'b0}};
            tdel_z_r <= {T_W{1'b0}};
            thresh_r <= 8'd0;
            steps_r  <= 8'd0;
            face_r   <= 3'd0;
            t_cur_r  <= {T_W{1'b0}};
            data_r   <= {DATA_W{1'b0}};
            status_r <= 2'd0;
        end else if (accept_s) begin
            id_r     <= ray_id;
            x_r      <= ray_vox_x;
            y_r      <= ray_vox_y;
            z_r      <= ray_vox_z;
            neg_r    <= ray_neg;
            tmax_x_r <= ray_tmax_x;
            tmax_y_r <= ray_tmax_y;
            tmax_z_r <= ray_tmax_z;
            tdel_x_r <= ray_tdel_x;
            tdel_y_r <= ray_tdel_y;
            tdel_z_r <= ray_tdel_z;
            thresh_r <= alpha_thresh;
            steps_r  <= 8'd0;
            face_r   <= FACE_START;
            t_cur_r  <= {T_W{1'b0}};
            status_r <= ST_HIT;
        end else if (req_fire_s) begin
            steps_r <= steps_r + 8'd1;
        end else if (rsp_fire_s) begin
            data_r <= mem_rsp_data;
            if (hit_s) begin
                status_r <= ST_HIT;
            end else if (limit_s) begin
                status_r <= ST_LIMIT;
            end else if (step_oog_s) begin
                status_r <= ST_EXIT;
            end else begin
                x_r      <= step_x_s;
                y_r      <= step_y_s;
                z_r      <= step_z_s;
                tmax_x_r <= step_tmax_x_s;
                tmax_y_r <= step_tmax_y_s;
                tmax_z_r <= step_tmax_z_s;
                t_cur_r  <= step_t_s;
                face_r   <= {step_sign_s, step_axis_s};
            end
        end else begin
            steps_r <= steps_r;
        end
    end

    assign ray_ready     = ray_ready_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = AW'(pack_addr(GRID_BITS, 16'(x_r), 16'(y_r), 16'(z_r)));
    assign res_valid     = res_valid_r;
    assign res_id        = id_r;
    assign res_status    = status_r;
    assign res_vox_x     = x_r;
    assign res_vox_y     = y_r;
    assign res_vox_z     = z_r;
    assign res_face      = face_r;
    assign res_steps     = steps_r;
    assign res_t         = t_cur_r;
    assign res_data      = data_r;

endmodule

// File: tb/tb_voxel_dda_marcher.sv
module tb_voxel_dda_marcher;

    localparam int GB = 6;
    localparam int TW = 24;
    localparam int MS = 16;
    localparam int DW = 64;
    localparam logic [23:0] ONES = 24'hFFFFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ray_valid, ray_ready;
    logic [15:0]   ray_id;
    logic [5:0]    ray_vox_x, ray_vox_y, ray_vox_z;
    logic [2:0]    ray_neg;
    logic [23:0]   ray_tmax_x, ray_tmax_y, ray_tmax_z;
    logic [23:0]   ray_tdel_x, ray_tdel_y, ray_tdel_z;
    logic [7:0]    alpha_thresh;
    logic          mem_req_valid, mem_req_ready;
    logic [17:0]   mem_req_addr;
    logic          mem_rsp_valid;
    logic [63:0]   mem_rsp_data;
    logic          res_valid, res_ready;
    logic [15:0]   res_id;
    logic [1:0]    res_status;
    logic [5:0]    res_vox_x, res_vox_y, res_vox_z;
    logic [2:0]    res_face;
    logic [7:0]    res_steps;
    logic [23:0]   res_t;
    logic [63:0]   res_data;

    always #5 clk = ~clk;

    voxel_dda_marcher #(.GRID_BITS(GB), .T_W(TW), .MAX_STEPS(MS), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_id(ray_id),
        .ray_vox_x(ray_vox_x), .ray_vox_y(ray_vox_y), .ray_vox_z(ray_vox_z),
        .ray_neg(ray_neg),
        .ray_tmax_x(ray_tmax_x), .ray_tmax_y(ray_tmax_y), .ray_tmax_z(ray_tmax_z),
        .ray_tdel_x(ray_tdel_x), .ray_tdel_y(ray_tdel_y), .ray_tdel_z(ray_tdel_z),
        .alpha_thresh(alpha_thresh),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_status(res_status),
        .res_vox_x(res_vox_x), .res_vox_y(res_vox_y), .res_vox_z(res_vox_z),
        .res_face(res_face), .res_steps(res_steps), .res_t(res_t), .res_data(res_data)
    );

    typedef struct {
        logic [15:0] id;
        logic [1:0]  status;
        logic [5:0]  x, y, z;
        logic [2:0]  face;
        logic [7:0]  steps;
        logic [23:0] t;
        logic [63:0] data;
    } exp_res_t;

    exp_res_t     res_q[$];
    logic [17:0]  addr_q[$];
    logic [7:0]   alpha_mem [logic [17:0]];
    int           errors = 0;
    int           checks = 0;
    int           rsp_lat = 0;

    function automatic logic [17:0] pk(input logic [5:0] x, input logic [5:0] y,
                                       input logic [5:0] z);
        return {x, y, z};
    endfunction

    function automatic logic [63:0] word(input logic [17:0] a);
        logic [7:0] al;
        al = alpha_mem.exists(a) ? alpha_mem[a] : 8'd0;
        return {16'hA5A5, al, 22'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_addr(input logic [5:0] x, input logic [5:0] y, input logic [5:0] z);
        addr_q.push_back(pk(x, y, z));
    endtask

    task automatic push_res(input logic [15:0] id, input logic [1:0] st,
                            input logic [5:0] x, input logic [5:0] y, input logic [5:0] z,
                            input logic [2:0] f, input logic [7:0] s, input logic [23:0] t);
        exp_res_t r;
        r.id = id; r.status = st; r.x = x; r.y = y; r.z = z;
        r.face = f; r.steps = s; r.t = t; r.data = word(pk(x, y, z));
        res_q.push_back(r);
    endtask

    task automatic send_ray(input logic [15:0] id,
                            input logic [5:0] x, input logic [5:0] y, input logic [5:0] z,
                            input logic [2:0] neg,
                            input logic [23:0] tmx, input logic [23:0] tmy, input logic [23:0] tmz,
                            input logic [23:0] tdx, input logic [23:0] tdy, input logic [23:0] tdz,
                            input logic [7:0] th);
        @(negedge clk);
        ray_id = id; ray_vox_x = x; ray_vox_y = y; ray_vox_z = z; ray_neg = neg;
        ray_tmax_x = tmx; ray_tmax_y = tmy; ray_tmax_z = tmz;
        ray_tdel_x = tdx; ray_tdel_y = tdy; ray_tdel_z = tdz;
        alpha_thresh = th;
        for (int i = 0; i < 100 && !ray_ready; i++) @(negedge clk);
        chk("ray_ready_wait", 64'(ray_ready), 64'd1);
        ray_valid = 1'b1;
        @(negedge clk);
        ray_valid = 1'b0;
        alpha_thresh = 8'hFF;
    endtask

    task automatic wait_done(input string tag);
        logic tmo;
        tmo = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (res_q.size() == 0) begin
                tmo = 1'b0;
                break;
            end
        end
        chk({tag, "_timeout"}, 64'(tmo), 64'd0);
        @(negedge clk);
        chk({tag, "_res_valid_low"}, 64'(res_valid), 64'd0);
        chk({tag, "_ray_ready_back"}, 64'(ray_ready), 64'd1);
        chk({tag, "_addrs_left"}, 64'(addr_q.size()), 64'd0);
    endtask

    // Memory model: records and checks each accepted request address, then
    // returns one response pulse rsp_lat cycles later.
    initial begin : responder
        logic        pend;
        int          cnt;
        logic [17:0] a;
        pend = 1'b0; cnt = 0; a = 18'd0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 64'd0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = word(a);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (!pend && rst_n && mem_req_valid && mem_req_ready) begin
                a = mem_req_addr;
                pend = 1'b1;
                cnt = rsp_lat;
                checks++;
                assert (addr_q.size() != 0) else begin
                    errors++;
                    $error("FAIL addr_extra: observed=%0h expected=none", a);
                end
                if (addr_q.size() != 0) chk("mem_addr", 64'(a), 64'(addr_q.pop_front()));
            end
        end
    end

    // Result monitor: every result handshake is matched against the scoreboard.
    initial begin : res_mon
        exp_res_t e;
        forever begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                checks++;
                assert (res_q.size() != 0) else begin
                    errors++;
                    $error("FAIL res_extra: observed id=%0h expected=none", res_id);
                end
                if (res_q.size() != 0) begin
                    e = res_q.pop_front();
                    chk("res_id",     64'(res_id),     64'(e.id));
                    chk("res_status", 64'(res_status), 64'(e.status));
                    chk("res_vox",    64'({res_vox_x, res_vox_y, res_vox_z}),
                                      64'({e.x, e.y, e.z}));
                    chk("res_face",   64'(res_face),   64'(e.face));
                    chk("res_steps",  64'(res_steps),  64'(e.steps));
                    chk("res_t",      64'(res_t),      64'(e.t));
                    chk("res_data",   res_data,        e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; ray_valid = 1'b0; ray_id = 16'd0;
        ray_vox_x = 6'd0; ray_vox_y = 6'd0; ray_vox_z = 6'd0; ray_neg = 3'd0;
        ray_tmax_x = 24'd0; ray_tmax_y = 24'd0; ray_tmax_z = 24'd0;
        ray_tdel_x = 24'd0; ray_tdel_y = 24'd0; ray_tdel_z = 24'd0;
        alpha_thresh = 8'd0; mem_req_ready = 1'b1; res_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ray_ready", 64'(ray_ready), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_res", 64'({res_status, res_face, res_steps, res_t}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ray_ready", 64'(ray_ready), 64'd1);

        // +x ray hitting an opaque voxel
        alpha_mem[pk(6'd3, 6'd5, 6'd5)] = 8'd200;
        for (int x = 0; x < 4; x++) push_addr(6'(x), 6'd5, 6'd5);
        push_res(16'h0001, 2'd0, 6'd3, 6'd5, 6'd5, 3'b000, 8'd4, 24'd768);
        send_ray(16'h0001, 6'd0, 6'd5, 6'd5, 3'b000, 24'd256, ONES, ONES,
                 24'd256, 24'd1, 24'd1, 8'd10);
        wait_done("hit_x");

        // -x ray leaving through the low edge
        alpha_mem.delete();
        push_addr(6'd1, 6'd0, 6'd0); push_addr(6'd0, 6'd0, 6'd0);
        push_res(16'h0002, 2'd1, 6'd0, 6'd0, 6'd0, 3'b100, 8'd2, 24'd50);
        send_ray(16'h0002, 6'd1, 6'd0, 6'd0, 3'b001, 24'd50, ONES, ONES,
                 24'd50, 24'd1, 24'd1, 8'd10);
        wait_done("exit_negx");

        // Step limit on an empty grid
        for (int x = 0; x < MS; x++) push_addr(6'(x), 6'd0, 6'd0);
        push_res(16'h0003, 2'd2, 6'd15, 6'd0, 6'd0, 3'b000, 8'd16, 24'd150);
        send_ray(16'h0003, 6'd0, 6'd0, 6'd0, 3'b000, 24'd10, ONES, ONES,
                 24'd10, 24'd1, 24'd1, 8'd10);
        wait_done("limit");

        // Tie-break x over y: x, y, x
        alpha_mem[pk(6'd2, 6'd1, 6'd0)] = 8'd50;
        push_addr(6'd0, 6'd0, 6'd0); push_addr(6'd1, 6'd0, 6'd0);
        push_addr(6'd1, 6'd1, 6'd0); push_addr(6'd2, 6'd1, 6'd0);
        push_res(16'h0004, 2'd0, 6'd2, 6'd1, 6'd0, 3'b000, 8'd4, 24'd200);
        send_ray(16'h0004, 6'd0, 6'd0, 6'd0, 3'b000, 24'd100, 24'd100, ONES,
                 24'd100, 24'd100, 24'd1, 8'd10);
        wait_done("tie");

        // Alpha equal to threshold is a miss; one above is a hit
        alpha_mem.delete();
        alpha_mem[pk(6'd1, 6'd0, 6'd0)] = 8'd10;
        alpha_mem[pk(6'd2, 6'd0, 6'd0)] = 8'd11;
        for (int x = 0; x < 3; x++) push_addr(6'(x), 6'd0, 6'd0);
        push_res(16'h0005, 2'd0, 6'd2, 6'd0, 6'd0, 3'b000, 8'd3, 24'd14);
        send_ray(16'h0005, 6'd0, 6'd0, 6'd0, 3'b000, 24'd7, ONES, ONES,
                 24'd7, 24'd1, 24'd1, 8'd10);
        wait_done("alpha_eq");

        // -z ray leaving through z=0
        alpha_mem.delete();
        push_addr(6'd4, 6'd4, 6'd1); push_addr(6'd4, 6'd4, 6'd0);
        push_res(16'h0006, 2'd1, 6'd4, 6'd4, 6'd0, 3'b110, 8'd2, 24'd30);
        send_ray(16'h0006, 6'd4, 6'd4, 6'd1, 3'b100, ONES, ONES, 24'd30,
                 24'd1, 24'd1, 24'd30, 8'd10);
        wait_done("exit_negz");

        // +y ray starting on the top edge: exits after the start voxel
        push_addr(6'd0, 6'd63, 6'd0);
        push_res(16'h0007, 2'd1, 6'd0, 6'd63, 6'd0, 3'b011, 8'd1, 24'd0);
        send_ray(16'h0007, 6'd0, 6'd63, 6'd0, 3'b000, ONES, 24'd5, ONES,
                 24'd1, 24'd5, 24'd1, 8'd10);
        wait_done("exit_posy");

        // Back-pressure on request, slow memory, back-pressure on result
        alpha_mem[pk(6'd3, 6'd5, 6'd5)] = 8'd200;
        rsp_lat = 7; mem_req_ready = 1'b0; res_ready = 1'b0;
        for (int x = 0; x < 4; x++) push_addr(6'(x), 6'd5, 6'd5);
        push_res(16'h0008, 2'd0, 6'd3, 6'd5, 6'd5, 3'b000, 8'd4, 24'd768);
        send_ray(16'h0008, 6'd0, 6'd5, 6'd5, 3'b000, 24'd256, ONES, ONES,
                 24'd256, 24'd1, 24'd1, 8'd10);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_req_addr", 64'(mem_req_addr), 64'(pk(6'd0, 6'd5, 6'd5)));
            @(negedge clk);
        end
        @(posedge clk); #1 mem_req_ready = 1'b1;
        begin
            logic tmo;
            tmo = 1'b1;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (res_valid) begin
                    tmo = 1'b0;
                    break;
                end
            end
            chk("slow_res_timeout", 64'(tmo), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("hold_res_valid", 64'(res_valid), 64'd1);
            chk("hold_ray_ready", 64'(ray_ready), 64'd0);
            chk("hold_res_steps", 64'(res_steps), 64'd4);
            chk("hold_res_t", 64'(res_t), 64'd768);
            chk("hold_res_vox_x", 64'(res_vox_x), 64'd3);
            @(negedge clk);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        wait_done("stall");
        rsp_lat = 0;

        // Reset while waiting on memory, followed by a stale response
        alpha_mem.delete();
        rsp_lat = 6;
        push_addr(6'd0, 6'd0, 6'd0);
        send_ray(16'h0009, 6'd0, 6'd0, 6'd0, 3'b000, 24'd10, ONES, ONES,
                 24'd10, 24'd1, 24'd1, 8'd10);
        for (int i = 0; i < 50 && addr_q.size() != 0; i++) @(negedge clk);
        chk("abort_req_seen", 64'(addr_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ray_ready", 64'(ray_ready), 64'd0);
        chk("abort_req_valid", 64'(mem_req_valid), 64'd0);
        chk("abort_res_valid", 64'(res_valid), 64'd0);
        chk("abort_addr", 64'(mem_req_addr), 64'd0);
        chk("abort_res", 64'({res_status, res_face, res_steps, res_t}), 64'd0);
        chk("abort_data", res_data, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stale_res_valid", 64'(res_valid), 64'd0);
            chk("stale_req_valid", 64'(mem_req_valid), 64'd0);
        end
        chk("stale_ray_ready", 64'(ray_ready), 64'd1);
        rsp_lat = 0;

        // Fresh ray after the abort completes normally
        alpha_mem[pk(6'd3, 6'd5, 6'd5)] = 8'd200;
        for (int x = 0; x < 4; x++) push_addr(6'(x), 6'd5, 6'd5);
        push_res(16'h000A, 2'd0, 6'd3, 6'd5, 6'd5, 3'b000, 8'd4, 24'd768);
        send_ray(16'h000A, 6'd0, 6'd5, 6'd5, 3'b000, 24'd256, ONES, ONES,
                 24'd256, 24'd1, 24'd1, 8'd10);
        wait_done("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
